// File: rtl/fft_output_streamer.sv
// fft_output_streamer: captures a 16-bin complex FFT frame and streams it bin by bin over valid/ready (digit-reversed order under FFT_DIGIT_REVERSE_EN)
module fft_output_streamer #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH*16-1:0]     frame_real,
  input  logic [WIDTH*16-1:0]     frame_imag,
  input  logic                    frame_valid,
  output logic                    frame_ready,
  output logic signed [WIDTH-1:0] out_real,
  output logic signed [WIDTH-1:0] out_imag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0]              out_index,
  output logic                    out_last,
  output logic                    overrun
);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt, w_addr;
  logic [WIDTH-1:0] r_re [16];
  logic [WIDTH-1:0] r_im [16];
  logic w_hs, w_cap;
`ifdef FFT_DIGIT_REVERSE_EN
  assign w_addr = {r_cnt[1:0], r_cnt[3:2]};
`else
  assign w_addr = r_cnt;
`endif
  assign out_valid   = r_state == STREAM;
  assign frame_ready = r_state == IDLE || (r_cnt == 4'd15 && out_ready);
  assign w_hs        = out_valid && out_ready;
  assign w_cap       = frame_valid && frame_ready;
  assign overrun     = frame_valid && !frame_ready;
  assign out_index   = out_valid ? r_cnt : 4'd0;
  assign out_last    = out_valid && r_cnt == 4'd15;
  assign out_real    = out_valid ? r_re[w_addr] : '0;
  assign out_imag    = out_valid ? r_im[w_addr] : '0;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_cap) begin
      w_state_nxt = STREAM;
      w_cnt_nxt   = 4'd0;
    end else if (w_hs) begin
      w_cnt_nxt   = r_cnt + 4'd1;
      w_state_nxt = r_cnt == 4'd15 ? IDLE : STREAM;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        r_re[i] <= '0;
        r_im[i] <= '0;
      end
    end else if (w_cap) begin
      for (int i = 0; i < 16; i++) begin
        r_re[i] <= frame_real[i*WIDTH +: WIDTH];
        r_im[i] <= frame_imag[i*WIDTH +: WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_fft_output_streamer.sv
// tb_fft_output_streamer: scoreboard bench for fft_output_streamer
module tb_fft_output_streamer;
  localparam int W = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [W*16-1:0] fr_re = '0, fr_im = '0;
  logic fv = 1'b0, ordy = 1'b0;
  logic frame_ready, out_valid, out_last, overrun;
  logic signed [W-1:0] out_real, out_imag;
  logic [3:0] out_index;
  typedef struct {logic [3:0] idx; logic [W-1:0] re; logic [W-1:0] im;} exp_t;
  exp_t q[$];
  int checks = 0, fails = 0, outstanding = 0;
  fft_output_streamer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .frame_real(fr_re), .frame_imag(fr_im),
    .frame_valid(fv), .frame_ready(frame_ready), .out_real(out_real),
    .out_imag(out_imag), .out_valid(out_valid), .out_ready(ordy),
    .out_index(out_index), .out_last(out_last), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // Bin k of the output stream is buffer position map(k).
  function automatic int map(input int k);
`ifdef FFT_DIGIT_REVERSE_EN
    return (k % 4) * 4 + k / 4;
`else
    return k;
`endif
  endfunction
  task automatic new_frame();
    for (int n = 0; n < 16; n++) begin
      fr_re[n*W +: W] = W'($urandom);
      fr_im[n*W +: W] = W'($urandom);
    end
  endtask
  // One clock: apply inputs, update the transaction-level model at the edge.
  task automatic cyc(input logic v, input logic r);
    logic acc;
    fv = v;
    ordy = r;
    @(posedge clk);
    if (!rst) begin
      acc = v && (outstanding == 0 || (outstanding == 1 && r));
      if (acc) begin
        for (int k = 0; k < 16; k++) q.push_back('{4'(k), fr_re[map(k)*W +: W], fr_im[map(k)*W +: W]});
        outstanding = 16;
      end else if (outstanding > 0 && r) outstanding--;
    end
    #1;
  endtask
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid", W'(out_valid), 0);
      chk("rst_real", out_real, 0);
      chk("rst_overrun", W'(overrun), 0);
    end else begin
      chk("frame_ready", W'(frame_ready), W'(q.size() == 0 || (q.size() == 1 && ordy)));
      chk("overrun", W'(overrun), W'(fv && !(q.size() == 0 || (q.size() == 1 && ordy))));
      chk("out_valid", W'(out_valid), W'(q.size() != 0));
      if (out_valid && q.size() != 0) begin
        chk("out_index", W'(out_index), W'(q[0].idx));
        chk("out_real", out_real, q[0].re);
        chk("out_imag", out_imag, q[0].im);
        chk("out_last", W'(out_last), W'(q[0].idx == 4'd15));
        if (ordy) void'(q.pop_front());
      end else if (!out_valid) begin
        chk("idle_zero", W'({out_real, out_imag, out_index, out_last} != 0), 0);
      end
    end
  end
  initial begin
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    cyc(0, 0);
    cyc(0, 0);
    rst = 1'b0;
    cyc(0, 1);
    // Ramp frame: real=n, imag=-n, full throughput.
    for (int n = 0; n < 16; n++) begin
      fr_re[n*W +: W] = W'(n);
      fr_im[n*W +: W] = W'(-n);
    end
    cyc(1, 1);
    for (int i = 0; i < 17; i++) cyc(0, 1);
    // Stall pattern 1,0,0,1.
    new_frame();
    cyc(1, 1);
    for (int i = 0; i < 80 && outstanding > 0; i++) cyc(0, pat[i%4]);
    cyc(0, 1);
    // Frame offered mid-stream is dropped.
    new_frame();
    cyc(1, 1);
    for (int i = 0; i < 20 && outstanding != 11; i++) cyc(0, 1);
    new_frame();
    cyc(1, 1);
    for (int i = 0; i < 20 && outstanding > 0; i++) cyc(0, 1);
    // Back-to-back frames at the last sample.
    new_frame();
    cyc(1, 1);
    for (int i = 0; i < 20 && outstanding != 1; i++) cyc(0, 1);
    new_frame();
    cyc(1, 1);
    for (int i = 0; i < 20 && outstanding > 0; i++) cyc(0, 1);
    // Reset in mid-stream.
    new_frame();
    cyc(1, 1);
    for (int i = 0; i < 20 && outstanding != 9; i++) cyc(0, 1);
    rst = 1'b1;
    q.delete();
    outstanding = 0;
    cyc(0, 1);
    cyc(0, 1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(0, 1);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom % 4 == 0) new_frame();
      cyc($urandom % 6 == 0, $urandom % 3 != 0);
    end
    for (int i = 0; i < 60 && q.size() != 0; i++) cyc(0, 1);
    chk("drain", W'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/fft_output_streamer.md
FFT_OUTPUT_STREAMER -- requirements
Module: fft_output_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving bits per real or imaginary sample component.
REQ-002 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port frame_real, input, WIDTH*16 bits: 16 real components; sample n occupies bits [(n+1)*WIDTH-1 -: WIDTH].
REQ-005 SHALL have port frame_imag, input, WIDTH*16 bits: imaginary components, packed the same way as frame_real.
REQ-006 SHALL have port frame_valid, input, 1 bit: frame bus holds a complete FFT result; driven by the FFT core's done/valid.
REQ-007 SHALL have port frame_ready, output, 1 bit: the streamer accepts a frame this cycle.
REQ-008 SHALL have port out_real, output, WIDTH bits, signed: streamed real component.
REQ-009 SHALL have port out_imag, output, WIDTH bits, signed: streamed imaginary component.
REQ-010 SHALL have port out_valid, output, 1 bit: out_* carries a valid sample.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the sample.
REQ-012 SHALL have port out_index, output, 4 bits: frequency-bin index k of the current sample.
REQ-013 SHALL have port out_last, output, 1 bit: asserted with out_valid when out_index==15.
REQ-014 SHALL have port overrun, output, 1 bit: one-cycle pulse when a frame is dropped.

Function
REQ-015 SHALL implement two states, IDLE and STREAM, plus a 4-bit sample counter cnt and a 16-entry complex capture buffer.
REQ-016 SHALL drive frame_ready = (state==IDLE) OR (state==STREAM AND cnt==15 AND out_ready).
REQ-017 SHALL, on frame_valid AND frame_ready at an edge, capture all 16 complex samples into the buffer, set cnt=0 and enter or remain in STREAM.
REQ-018 SHALL assert out_valid in every STREAM cycle, starting the cycle after capture, which gives 1-cycle capture-to-first-sample latency.
REQ-019 SHALL drive out_index=cnt, out_real/out_imag from buffer entry map(cnt), and out_last=(cnt==15) while in STREAM.
REQ-020 SHALL drive out_real, out_imag, out_index and out_last to 0 whenever out_valid==0.
REQ-021 SHALL increment cnt on out_valid AND out_ready, and SHALL hold all out_* stable while out_valid AND NOT out_ready.
REQ-022 SHALL, on a handshake with cnt==15, return to IDLE unless a new frame is captured in the same cycle (REQ-017); back-to-back frames therefore stream with no gap.
REQ-023 SHALL, on frame_valid while frame_ready==0, drop that frame, leave the buffer untouched, and pulse overrun high for exactly that cycle.
REQ-024 SHALL treat frame_valid held high across several cycles as one frame per accepted cycle; each cycle counts independently for capture or overrun.
REQ-025 SHALL perform no arithmetic on sample values; bits pass unmodified.

Reset
REQ-026 SHALL, on rst high and independent of clk, force state=IDLE, cnt=0, buffer=0, out_valid=0, out_last=0, out_index=0, out_real=0, out_imag=0 and overrun=0.
REQ-027 SHALL abort any in-progress stream on reset; no sample of that frame appears after reset is released.
REQ-028 SHALL present frame_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-029 SHALL support macro FFT_DIGIT_REVERSE_EN: when defined, map(k)={k[1:0],k[3:2]} (base-4 digit reversal), so bins stream in natural order 0..15.
REQ-030 SHALL, when FFT_DIGIT_REVERSE_EN is undefined, use map(k)=k, streaming buffer order unchanged with out_index equal to buffer position.

Verification
REQ-031 SHALL cover: frame with sample n real=n, imag=-n; out_ready=1; macro off -> out_real 0..15 on 16 consecutive cycles starting 1 cycle after capture, out_last only on the 16th.
REQ-032 SHALL cover: same frame, macro on -> out_real sequence 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15 with out_index 0..15.
REQ-033 SHALL cover: out_ready toggled 1,0,0,1 repeatedly -> each sample held stable while stalled; no sample lost or repeated; 16 handshakes total.
REQ-034 SHALL cover: second frame_valid at cnt==5 -> overrun pulses exactly 1 cycle; first frame completes intact; second frame never streamed.
REQ-035 SHALL cover: frame B presented at cnt==15 with out_ready=1 -> B sample 0 appears on the next cycle, no idle cycle.
REQ-036 SHALL cover: rst pulsed at cnt==7 -> out_valid=0 immediately and stays low; frame_ready=1 after release.
